// File: rtl/reg_op_ctrl.sv
// Command sequencer for the 4x8 register group: accepts one register-transfer
// command, reads both operands, computes an 8-bit result and writes it back.
module reg_op_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_sr,
  input  logic [1:0] cmd_dr,
  input  logic [7:0] cmd_imm,
  output logic       rf_we,
  output logic [1:0] rf_sr,
  output logic [1:0] rf_dr,
  output logic [7:0] rf_i,
  input  logic [7:0] rf_s,
  input  logic [7:0] rf_d,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  state_e        state_q,     state_d;
  op_e           op_q,        op_d;
  logic [DW-1:0] imm_q,       imm_d;
  logic [DW-1:0] ops_q,       ops_d;
  logic [DW-1:0] opd_q,       opd_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rf_we_q,     rf_we_d;
  logic [AW-1:0] rf_sr_q,     rf_sr_d;
  logic [AW-1:0] rf_dr_q,     rf_dr_d;
  logic [DW-1:0] rf_i_q,      rf_i_d;
  logic [DW-1:0] result_q,    result_d;
  logic          zero_q,      zero_d;
  logic          carry_q,     carry_d;
  logic          done_q,      done_d;
  logic [DW:0]   alu;

  // 9-bit ALU: bit DW is ADD carry-out or SUB borrow
  always_comb begin
    alu = '0;
    case (op_q)
      OP_LOAD: alu = {1'b0, imm_q};
      OP_MOV:  alu = {1'b0, ops_q};
      OP_ADD:  alu = {1'b0, opd_q} + {1'b0, ops_q};
      OP_SUB:  alu = {1'b0, opd_q} - {1'b0, ops_q};
      default: alu = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    ops_d    = ops_q;
    opd_d    = opd_q;
    rf_we_d  = 1'b0;
    rf_sr_d  = rf_sr_q;
    rf_dr_d  = rf_dr_q;
    rf_i_d   = rf_i_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          imm_d   = cmd_imm;
          rf_sr_d = cmd_sr;
          rf_dr_d = cmd_dr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        ops_d   = rf_s;
        opd_d   = rf_d;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu[DW-1:0];
        zero_d   = (alu[DW-1:0] == DW'(0));
        carry_d  = alu[DW];
        rf_i_d   = alu[DW-1:0];
        rf_we_d  = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      imm_q       <= '0;
      ops_q       <= '0;
      opd_q       <= '0;
      cmd_ready_q <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_sr_q     <= '0;
      rf_dr_q     <= '0;
      rf_i_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      ops_q       <= ops_d;
      opd_q       <= opd_d;
      cmd_ready_q <= cmd_ready_d;
      rf_we_q     <= rf_we_d;
      rf_sr_q     <= rf_sr_d;
      rf_dr_q     <= rf_dr_d;
      rf_i_q      <= rf_i_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_sr     = rf_sr_q;
  assign rf_dr     = rf_dr_q;
  assign rf_i      = rf_i_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign done      = done_q;

endmodule
